// File: rtl/boot_rom_copier_if.sv
// boot_rom_copier_if: boot ROM read port (CSN/A/Q) and RAM req/gnt write port of the copy engine.
interface boot_rom_copier_if #(
   parameter int ROM_AW = 10,
   parameter int MEM_AW = 16
);
   logic              rom_csn_o;
   logic [ROM_AW-1:0] rom_a_o;
   logic [31:0]       rom_q_i;
   logic              mem_req_o;
   logic              mem_we_o;
   logic [MEM_AW-1:0] mem_addr_o;
   logic [31:0]       mem_wdata_o;
   logic [3:0]        mem_be_o;
   logic              mem_gnt_i;
   modport master (
      output rom_csn_o, rom_a_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
      input  rom_q_i, mem_gnt_i
   );
   modport slave (
      input  rom_csn_o, rom_a_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
      output rom_q_i, mem_gnt_i
   );
endinterface

// File: rtl/boot_rom_copier.sv
// boot_rom_copier: streams a block of words from the boot ROM into RAM, summing them on the way.
module boot_rom_copier #(
   parameter int ROM_AW = 10,
   parameter int MEM_AW = 16
) (
   input  logic              CLK,
   input  logic              RSTN,
   input  logic              start_i,
   input  logic [ROM_AW-1:0] src_base_i,
   input  logic [MEM_AW-1:0] dst_base_i,
   input  logic [ROM_AW:0]   len_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [31:0]       checksum_o,
   boot_rom_copier_if.master bus
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [ROM_AW-1:0] src_q, src_d;
   logic [MEM_AW-1:0] dst_q, dst_d;
   logic [ROM_AW:0]   rem_q, rem_d;
   logic [31:0]       sum_q, sum_d;
   logic              accept, go, fire, last, rd;

   always_comb begin
      accept  = state_q == IDLE && start_i;
      go      = accept && len_i != '0;
      fire    = state_q == WRITE && bus.mem_gnt_i;
      last    = rem_q == (ROM_AW+1)'(1);
      // the next word is fetched while the current one is granted, so ROM Q stays put during stalls
      rd      = state_q == READ || (fire && !last);
      state_d = accept ? (go ? READ : DONE) :
                state_q == READ ? WRITE :
                fire && last ? DONE :
                state_q == DONE ? IDLE : state_q;
      src_d   = go ? src_base_i : rd ? src_q + 1'b1 : src_q;
      dst_d   = go ? dst_base_i : fire ? dst_q + 1'b1 : dst_q;
      rem_d   = go ? len_i : fire ? rem_q - 1'b1 : rem_q;
      sum_d   = accept ? '0 : fire ? sum_q + bus.rom_q_i : sum_q;
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         rem_q   <= rem_d;
         sum_q   <= sum_d;
      end
   end

   assign busy_o          = state_q == READ || state_q == WRITE;
   assign done_o          = state_q == DONE;
   assign checksum_o      = sum_q;
   assign bus.rom_csn_o   = !rd;
   assign bus.rom_a_o     = src_q;
   assign bus.mem_req_o   = state_q == WRITE;
   assign bus.mem_we_o    = bus.mem_req_o;
   assign bus.mem_addr_o  = dst_q;
   assign bus.mem_wdata_o = bus.rom_q_i;
   assign bus.mem_be_o    = bus.mem_req_o ? 4'hF : 4'h0;
endmodule

// File: tb/tb_boot_rom_copier.sv
// tb_boot_rom_copier: random and directed copies checked against a word-list model of the copy.
module tb_boot_rom_copier;
   logic        CLK = 1'b0;
   logic        RSTN = 1'b0;
   logic        start = 1'b0;
   logic [9:0]  src_base = '0;
   logic [15:0] dst_base = '0;
   logic [10:0] len = '0;
   logic        busy, done;
   logic [31:0] checksum;

   boot_rom_copier_if #(.ROM_AW(10), .MEM_AW(16)) bus();

   boot_rom_copier #(.ROM_AW(10), .MEM_AW(16)) dut (
      .CLK(CLK), .RSTN(RSTN), .start_i(start), .src_base_i(src_base), .dst_base_i(dst_base),
      .len_i(len), .busy_o(busy), .done_o(done), .checksum_o(checksum), .bus(bus)
   );

   always #5 CLK = ~CLK;

   logic [31:0] rom_mem [1024];
   logic [9:0]  ra_q = '0;
   always @(posedge CLK) if (!bus.rom_csn_o) ra_q <= bus.rom_a_o;
   assign bus.rom_q_i = rom_mem[ra_q];

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [9:0]  rd_log [$];
   logic [15:0] wa_log [$];
   logic [31:0] wd_log [$];
   bit          prev_stall = 0;
   logic [15:0] hold_a;
   logic [31:0] hold_d;

   always @(negedge CLK) begin
      if (!bus.rom_csn_o) rd_log.push_back(bus.rom_a_o);
      if (bus.mem_req_o && bus.mem_gnt_i) begin
         wa_log.push_back(bus.mem_addr_o);
         wd_log.push_back(bus.mem_wdata_o);
         chk("write_we", bus.mem_we_o, 1);
         chk("write_be", bus.mem_be_o, 4'hF);
      end
      if (prev_stall && bus.mem_req_o) begin
         chk("hold_addr", bus.mem_addr_o, hold_a);
         chk("hold_data", bus.mem_wdata_o, hold_d);
      end
      prev_stall = bus.mem_req_o && !bus.mem_gnt_i;
      if (prev_stall) begin
         hold_a = bus.mem_addr_o;
         hold_d = bus.mem_wdata_o;
         chk("stall_csn", bus.rom_csn_o, 1);
      end
   end

   int stalls [$];
   int widx = 0;
   int stall_left = 0;

   // per-word stall budget: gnt stays low for stalls[w] requested cycles, then grants
   initial begin
      bus.mem_gnt_i = 1'b0;
      forever begin
         @(posedge CLK);
         #1;
         if (bus.mem_req_o) begin
            if (stall_left > 0) begin
               bus.mem_gnt_i = 1'b0;
               stall_left--;
            end else begin
               bus.mem_gnt_i = 1'b1;
               widx++;
               stall_left = widx < stalls.size() ? stalls[widx] : 0;
            end
         end else bus.mem_gnt_i = 1'($urandom_range(0, 1));
      end
   end

   task automatic check_reset(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_sum"}, checksum, 0);
      chk({tag, "_csn"}, bus.rom_csn_o, 1);
      chk({tag, "_rom_a"}, bus.rom_a_o, 0);
      chk({tag, "_req"}, bus.mem_req_o, 0);
      chk({tag, "_we"}, bus.mem_we_o, 0);
      chk({tag, "_addr"}, bus.mem_addr_o, 0);
      chk({tag, "_be"}, bus.mem_be_o, 0);
   endtask

   task automatic run_copy(input string nm, input logic [9:0] s, input logic [15:0] d,
                           input logic [10:0] n, input bit noise);
      int exp_edges, e, st;
      logic [31:0] sum;
      logic [9:0]  ra;
      logic [15:0] wa;
      st = 0;
      foreach (stalls[i]) st += stalls[i];
      exp_edges = n == 0 ? 0 : int'(n) + 1 + st;
      sum = '0;
      for (int i = 0; i < int'(n); i++) begin
         ra = s + 10'(i);
         sum = sum + rom_mem[ra];
      end
      widx = 0;
      stall_left = stalls.size() > 0 ? stalls[0] : 0;
      @(posedge CLK);
      #1;
      rd_log.delete();
      wa_log.delete();
      wd_log.delete();
      start = 1'b1;
      src_base = s;
      dst_base = d;
      len = n;
      @(posedge CLK);
      #1;
      start = noise;
      src_base = 10'($urandom);
      dst_base = 16'($urandom);
      len = 11'($urandom_range(0, 8));
      e = 0;
      forever begin
         @(negedge CLK);
         if (done || e > exp_edges + 20) break;
         if (n != 0) chk({nm, "_busy"}, busy, 1);
         @(posedge CLK);
         #1;
         if (noise) start = 1'($urandom_range(0, 1));
         e++;
      end
      start = 1'b0;
      chk({nm, "_done_cycle"}, e, exp_edges);
      chk({nm, "_busy_in_done"}, busy, 0);
      @(negedge CLK);
      chk({nm, "_done_pulse"}, done, 0);
      repeat (2) @(negedge CLK);
      chk({nm, "_idle_after"}, busy, 0);
      chk({nm, "_reads"}, rd_log.size(), n);
      chk({nm, "_writes"}, wa_log.size(), n);
      for (int i = 0; i < int'(n) && i < rd_log.size() && i < wa_log.size(); i++) begin
         ra = s + 10'(i);
         wa = d + 16'(i);
         chk({nm, "_rd_addr"}, rd_log[i], ra);
         chk({nm, "_wr_addr"}, wa_log[i], wa);
         chk({nm, "_wr_data"}, wd_log[i], rom_mem[ra]);
      end
      chk({nm, "_checksum"}, checksum, sum);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) rom_mem[i] = $urandom;
      for (int i = 0; i < 4; i++) rom_mem[16 + i] = 32'(i + 1);
      rom_mem[10'h200] = 32'hFFFF_FFFF;
      rom_mem[10'h201] = 32'h0000_0002;
      repeat (3) @(negedge CLK);
      check_reset("reset");
      RSTN = 1'b1;
      repeat (2) @(negedge CLK);
      check_reset("post_reset");

      stalls = {};
      run_copy("basic", 10'h010, 16'h0100, 11'd4, 0);
      chk("basic_sum10", checksum, 32'd10);
      stalls = {0, 0, 3, 0};
      run_copy("stall", 10'h010, 16'h0100, 11'd4, 0);
      chk("stall_sum10", checksum, 32'd10);
      stalls = {};
      run_copy("len0", 10'h055, 16'h1234, 11'd0, 1);
      chk("len0_sum0", checksum, 32'd0);
      stalls = {1, 0, 2};
      run_copy("wrap", 10'h3FE, 16'hFFFF, 11'd3, 0);
      stalls = {};
      run_copy("ovf", 10'h200, 16'h0040, 11'd2, 1);
      chk("ovf_sum1", checksum, 32'd1);
      run_copy("full", 10'($urandom), 16'($urandom), 11'd1024, 0);

      for (int t = 0; t < 25; t++) begin
         int n;
         n = $urandom_range(1, 40);
         stalls = {};
         for (int w = 0; w < n; w++)
            stalls.push_back($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);
         run_copy("rand", 10'($urandom), 16'($urandom), 11'(n), 1'($urandom_range(0, 1)));
      end

      stalls = {0, 2, 0, 1, 0, 0, 0, 0};
      widx = 0;
      stall_left = 0;
      @(posedge CLK);
      #1;
      start = 1'b1;
      src_base = 10'h123;
      dst_base = 16'h4000;
      len = 11'd8;
      @(posedge CLK);
      #1;
      start = 1'b0;
      repeat (4) @(posedge CLK);
      @(negedge CLK);
      chk("midcopy_busy", busy, 1);
      RSTN = 1'b0;
      @(negedge CLK);
      check_reset("midcopy_reset");
      @(negedge CLK);
      RSTN = 1'b1;
      repeat (2) @(negedge CLK);
      check_reset("midcopy_release");
      stalls = {};
      run_copy("after_rst", 10'h123, 16'h4000, 11'd8, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/boot_rom_copier.md
# boot_rom_copier

Hardware boot-copy engine acting as the read initiator on the boot ROM port (CSN/A/Q, one-cycle registered-address read). On a start pulse it streams a block of 32-bit words out of the boot ROM and writes them into instruction/data RAM over a req/gnt write port. It sits beside the boot ROM so the core can come out of reset with RAM already populated. It also accumulates a 32-bit checksum of the copied words for software or the testbench to check.

## Interface
- ROM_AW, default 10: boot ROM word-address width.
- MEM_AW, default 16: destination RAM word-address width.
- CLK  in  1  clock; all state changes on rising edge.
- RSTN  in  1  reset, asynchronous, active-low.
- start_i  in  1  start pulse; sampled only in IDLE.
- src_base_i  in  ROM_AW  first ROM word address; sampled with start_i.
- dst_base_i  in  MEM_AW  first RAM word address; sampled with start_i.
- len_i  in  ROM_AW+1  number of words to copy (0..2^ROM_AW); sampled with start_i.
- busy_o  out  1  copy in progress.
- done_o  out  1  one-cycle completion pulse.
- checksum_o  out  32  wrapping sum of all words written by the current or last copy.
- rom_csn_o  out  1  ROM chip select, active-low.
- rom_a_o  out  ROM_AW  ROM word address.
- rom_q_i  in  32  ROM read data; valid the cycle after a CSN-low edge; held while CSN is high.
- mem_req_o  out  1  RAM write request.
- mem_we_o  out  1  write enable; equals mem_req_o.
- mem_addr_o  out  MEM_AW  RAM word address.
- mem_wdata_o  out  32  RAM write data.
- mem_be_o  out  4  byte enables; 4'hF while mem_req_o is high, else 0.
- mem_gnt_i  in  1  RAM grant; a write completes on an edge where req and gnt are both high.

## Operation
FSM states: IDLE, READ, WRITE, DONE.

- **IDLE**
  - rom_csn_o=1, mem_req_o=0, busy_o=0.
  - On start_i with len_i≠0: latch the bases into src_ptr/dst_ptr, load remaining=len_i, clear checksum, go to READ.
  - On start_i with len_i=0: clear checksum, go to DONE.
- **READ**
  - rom_csn_o=0, rom_a_o=src_ptr. Go to WRITE. src_ptr increments.
- **WRITE**
  - mem_req_o=1, mem_addr_o=dst_ptr, mem_wdata_o=rom_q_i (combinational pass-through).
  - When mem_gnt_i=0: hold all outputs. rom_csn_o=1 so the ROM's registered address, and therefore Q, stays stable.
  - When mem_gnt_i=1:
    - checksum += rom_q_i (mod 2^32), dst_ptr++, remaining--.
    - If remaining was 1, go to DONE.
    - Otherwise, in the same cycle drive rom_csn_o=0 with rom_a_o=src_ptr (prefetch), src_ptr++, and stay in WRITE.
  - Prefetch is enabled combinationally by mem_gnt_i.
- **DONE**
  - done_o=1, busy_o=0, no requests. Go to IDLE.
- busy_o=1 in READ and WRITE only.
- start_i outside IDLE is ignored, including in DONE.
- Pointer wrap: src_ptr wraps mod 2^ROM_AW and dst_ptr wraps mod 2^MEM_AW, silently. A full-size copy (len=2^ROM_AW) is legal.
- checksum_o holds its value from DONE until the next accepted start.

## Timing
- Reset values:
  - FSM=IDLE.
  - busy_o=0, done_o=0, checksum_o=0.
  - rom_csn_o=1, rom_a_o=0.
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=rom_q_i (don't-care), mem_be_o=0.
- Reset asserted mid-copy: immediate return to IDLE with the values above. A RAM write in flight is abandoned and the partial checksum is lost.
- Start accepted at edge k:
  - cycle k+1: READ.
  - cycle k+2: first mem_req_o.
- With mem_gnt_i tied high:
  - one word per cycle; N words complete at edge k+N+1.
  - done_o high in cycle k+N+2.
- Each gnt=0 cycle adds exactly one cycle of latency. Data and address stay stable across stalls.
- len=0: done_o in cycle k+1, with no ROM or RAM access.
- mem_req_o never deasserts between consecutive words while gnt=1. The ROM is never read twice for the same word.

## Test plan
1. Reset, then hold: all outputs equal their reset values. Assert RSTN mid-copy and check the same values the next cycle.
2. ROM words 0x10..0x13 = 1,2,3,4; start with src=0x10, dst=0x0100, len=4, gnt=1 → writes 1..4 to 0x0100..0x0103 on four consecutive cycles; done_o 6 cycles after start; checksum_o=10.
3. Same copy with gnt low for 3 cycles on word 2 → req, addr 0x0102 and data 3 held stable; no extra ROM reads; done_o 3 cycles later; checksum_o=10.
4. len=0 → done_o the cycle after start; no rom_csn_o=0 and no mem_req_o; checksum_o=0.
5. Wrap: src=0x3FE, dst=0xFFFF, len=3 → ROM reads at 0x3FE, 0x3FF, 0x000; RAM writes at 0xFFFF, 0x0000, 0x0001.
6. Checksum overflow: words 0xFFFFFFFF and 0x00000002 → checksum_o=0x00000001. A start pulsed while busy is ignored.
